// File: rtl/rs_issue_scheduler.sv
// Purpose: round-robin pick of one ready reservation-station entry per cycle into a registered exec slot.
// Latency: grant is combinational in the cycle an entry is ready (slot empty or draining); op visible next cycle.
// Backpressure: exec_ready_i low holds the slot and suppresses grants; flush_i empties the slot, no grant.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush_i              drop held op, block grant this cycle
//   rs_entries_i         snapshot of all RS entries
//   exec_ready_i         execute side accepts exec_op_o this cycle
//   issue_grant_o        one-hot grant pulse back to the RS (entry clears busy)
//   exec_valid_o/op/idx  registered op slot toward execute
//   issue_count_o        ops accepted by execute, wraps at 2^32

package rs_issue_scheduler_pkg;
    typedef struct packed {
        logic        busy;
        logic [13:0] op;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
    } res_st_cell_t;
endpackage

module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  res_st_cell_t [NUM_ENTRIES-1:0]      rs_entries_i,
    input  logic                                exec_ready_i,
    output logic [NUM_ENTRIES-1:0]              issue_grant_o,
    output logic                                exec_valid_o,
    output res_st_cell_t                        exec_op_o,
    output logic [IDX_W-1:0]                    exec_idx_o,
    output logic [31:0]                         issue_count_o
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q;
    logic              exec_valid_q;
    res_st_cell_t      exec_op_q;
    logic [IDX_W-1:0]  exec_idx_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic [31:0]       count_q;

    logic [NUM_ENTRIES-1:0] ready;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W:0]         cand;
    logic                   load;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = rs_entries_i[i].busy && (rs_entries_i[i].qj == '0) && (rs_entries_i[i].qk == '0);
        end
    end

    // Walk from rr_ptr upward with modulo wrap; one extra bit keeps the sum
    // exact before the wrap subtraction, so non-power-of-two sizes also work.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_ENTRIES)) begin
                cand = cand - (IDX_W+1)'(NUM_ENTRIES);
            end
            if (!found && ready[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    assign load     = !flush_i && found && ((state_q == IDLE) || exec_ready_i);
    assign rr_ptr_d = (winner == IDX_W'(NUM_ENTRIES - 1)) ? '0 : winner + IDX_W'(1);

    // Grant is withheld during reset so the RS never frees an entry whose
    // op would be thrown away by the reset of the slot.
    always_comb begin
        issue_grant_o = '0;
        if (load && rst_n) begin
            issue_grant_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exec_valid_q <= 1'b0;
            exec_op_q    <= '0;
            exec_idx_q   <= '0;
            rr_ptr_q     <= '0;
            count_q      <= '0;
        end else if (flush_i) begin
            // Held op is dropped uncounted; pointer and stale payload are kept.
            state_q      <= IDLE;
            exec_valid_q <= 1'b0;
        end else begin
            if (exec_valid_q && exec_ready_i) begin
                count_q <= count_q + 32'd1;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q      <= HOLD;
                        exec_valid_q <= 1'b1;
                        exec_op_q    <= rs_entries_i[winner];
                        exec_idx_q   <= winner;
                        rr_ptr_q     <= rr_ptr_d;
                    end
                end
                HOLD: begin
                    if (exec_ready_i) begin
                        if (load) begin
                            exec_op_q  <= rs_entries_i[winner];
                            exec_idx_q <= winner;
                            rr_ptr_q   <= rr_ptr_d;
                        end else begin
                            state_q      <= IDLE;
                            exec_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    exec_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign exec_valid_o  = exec_valid_q;
    assign exec_op_o     = exec_op_q;
    assign exec_idx_o    = exec_idx_q;
    assign issue_count_o = count_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Purpose: directed checks of rs_issue_scheduler arbitration, slot handshake, flush and reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: exec_ready_i driven directly by the stimulus sequence.

module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    localparam int N = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     flush_i;
    res_st_cell_t [N-1:0]     rs;
    logic                     exec_ready_i;
    logic [N-1:0]             issue_grant_o;
    logic                     exec_valid_o;
    res_st_cell_t             exec_op_o;
    logic [2:0]               exec_idx_o;
    logic [31:0]              issue_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    rs_issue_scheduler #(.NUM_ENTRIES(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .rs_entries_i  (rs),
        .exec_ready_i  (exec_ready_i),
        .issue_grant_o (issue_grant_o),
        .exec_valid_o  (exec_valid_o),
        .exec_op_o     (exec_op_o),
        .exec_idx_o    (exec_idx_o),
        .issue_count_o (issue_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_st_cell_t mk(input logic [13:0] op, input logic [3:0] qj, input logic [3:0] qk,
                                        input logic [31:0] vj, input logic [31:0] vk);
        res_st_cell_t c;
        c.busy = 1'b1;
        c.op   = op;
        c.qj   = qj;
        c.qk   = qk;
        c.vj   = vj;
        c.vk   = vk;
        c.a    = 32'd0;
        return c;
    endfunction

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        exec_ready_i = 1'b1;
        for (int i = 0; i < N; i++) rs[i] = mk(14'(i), 4'd0, 4'd0, 32'(i), 32'd0);

        // 1. reset with all entries ready: no grants, reset values afterwards
        #1;
        check_eq("rst_grant0", issue_grant_o, 0);
        tick(); #1;
        check_eq("rst_grant1", issue_grant_o, 0);
        tick(); #1;
        check_eq("rst_grant2", issue_grant_o, 0);
        check_eq("rst_valid", exec_valid_o, 0);
        check_eq("rst_count", issue_count_o, 0);
        rst_n = 1'b1;
        rs    = '0;
        tick(); #1;
        check_eq("rel_valid", exec_valid_o, 0);
        check_eq("rel_count", issue_count_o, 0);

        // 2. single op on entry 3
        rs[3] = mk(14'b01111000000000, 4'd0, 4'd0, 32'd20, 32'd10);
        #1;
        check_eq("t2_grant", issue_grant_o, 8'b0000_1000);
        tick();
        rs[3].busy = 1'b0;
        #1;
        check_eq("t2_valid", exec_valid_o, 1);
        check_eq("t2_idx", exec_idx_o, 3);
        check_eq("t2_vj", exec_op_o.vj, 20);
        check_eq("t2_op", exec_op_o.op, 14'b01111000000000);
        // rr_ptr is 4: with entries 3 and 5 ready, 5 must win (back-to-back from HOLD)
        rs[3] = mk(14'd3, 4'd0, 4'd0, 32'd3, 32'd0);
        rs[5] = mk(14'd5, 4'd0, 4'd0, 32'd5, 32'd0);
        #1;
        check_eq("t2_rr_grant", issue_grant_o, 8'b0010_0000);
        tick();
        rs = '0;
        #1;
        check_eq("t2_idx5", exec_idx_o, 5);
        check_eq("t2_count", issue_count_o, 1);

        // 3. round-robin 0, 2, 7, 0 from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rs[0] = mk(14'd10, 4'd0, 4'd0, 32'd100, 32'd0);
        rs[2] = mk(14'd12, 4'd0, 4'd0, 32'd102, 32'd0);
        rs[7] = mk(14'd17, 4'd0, 4'd0, 32'd107, 32'd0);
        #1;
        check_eq("t3_g0", issue_grant_o, 8'b0000_0001);
        check_eq("t3_cnt0", issue_count_o, 0);
        tick(); #1;
        check_eq("t3_g2", issue_grant_o, 8'b0000_0100);
        check_eq("t3_idx0", exec_idx_o, 0);
        check_eq("t3_cnt_a", issue_count_o, 0);
        tick(); #1;
        check_eq("t3_g7", issue_grant_o, 8'b1000_0000);
        check_eq("t3_idx2", exec_idx_o, 2);
        check_eq("t3_cnt1", issue_count_o, 1);
        tick(); #1;
        check_eq("t3_gwrap", issue_grant_o, 8'b0000_0001);
        check_eq("t3_idx7", exec_idx_o, 7);
        check_eq("t3_cnt2", issue_count_o, 2);
        tick();
        rs = '0;
        #1;
        check_eq("t3_idx0b", exec_idx_o, 0);
        check_eq("t3_cnt3", issue_count_o, 3);
        check_eq("t3_nogrant", issue_grant_o, 0);
        tick(); #1;
        check_eq("t3_idle", exec_valid_o, 0);
        check_eq("t3_cnt4", issue_count_o, 4);

        // 4. stall in HOLD for 3 cycles, entry 5 waiting (rr_ptr = 1)
        rs[6] = mk(14'd6, 4'd0, 4'd0, 32'd66, 32'd0);
        #1;
        check_eq("t4_g6", issue_grant_o, 8'b0100_0000);
        tick();
        rs[6].busy   = 1'b0;
        rs[5]        = mk(14'd5, 4'd0, 4'd0, 32'd55, 32'd0);
        exec_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq($sformatf("t4_stall_grant%0d", c), issue_grant_o, 0);
            check_eq($sformatf("t4_stall_vj%0d", c), exec_op_o.vj, 66);
            check_eq($sformatf("t4_stall_valid%0d", c), exec_valid_o, 1);
            if (c < 2) tick();
        end
        tick();
        exec_ready_i = 1'b1;
        #1;
        check_eq("t4_g5", issue_grant_o, 8'b0010_0000);
        check_eq("t4_idx6", exec_idx_o, 6);
        tick();
        rs[5].busy = 1'b0;
        #1;
        check_eq("t4_idx5", exec_idx_o, 5);
        check_eq("t4_cnt5", issue_count_o, 5);
        tick(); #1;
        check_eq("t4_idle", exec_valid_o, 0);
        check_eq("t4_cnt6", issue_count_o, 6);

        // 5. operand wait on entry 1 (qj = 4)
        rs[1] = mk(14'd1, 4'd4, 4'd0, 32'd5, 32'd10);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq($sformatf("t5_wait_grant%0d", c), issue_grant_o, 0);
            check_eq($sformatf("t5_wait_valid%0d", c), exec_valid_o, 0);
            tick();
        end
        rs[1].qj = 4'd0;
        #1;
        check_eq("t5_g1", issue_grant_o, 8'b0000_0010);
        tick();
        rs[1].busy = 1'b0;
        #1;
        check_eq("t5_idx1", exec_idx_o, 1);
        check_eq("t5_vj", exec_op_o.vj, 5);
        tick(); #1;
        check_eq("t5_cnt7", issue_count_o, 7);

        // 6a. flush while HOLD with exec_ready_i = 1 (rr_ptr = 2)
        rs[4] = mk(14'd4, 4'd0, 4'd0, 32'd44, 32'd0);
        #1;
        check_eq("t6_g4", issue_grant_o, 8'b0001_0000);
        tick();
        rs[4].busy = 1'b0;
        rs[2]      = mk(14'd2, 4'd0, 4'd0, 32'd22, 32'd0);
        flush_i    = 1'b1;
        #1;
        check_eq("t6_flush_grant", issue_grant_o, 0);
        check_eq("t6_flush_held", exec_valid_o, 1);
        tick();
        flush_i = 1'b0;
        rs[2].busy = 1'b0;
        #1;
        check_eq("t6_flush_valid", exec_valid_o, 0);
        check_eq("t6_flush_cnt", issue_count_o, 7);

        // 6b. reset while HOLD (rr_ptr = 5 -> entry 0 wins)
        rs[0] = mk(14'd9, 4'd0, 4'd0, 32'd99, 32'd0);
        #1;
        check_eq("t6_g0", issue_grant_o, 8'b0000_0001);
        tick();
        rs[0].busy = 1'b0;
        rs[1]      = mk(14'd1, 4'd0, 4'd0, 32'd11, 32'd0);
        rs[3]      = mk(14'd3, 4'd0, 4'd0, 32'd33, 32'd0);
        rst_n      = 1'b0;
        #1;
        check_eq("t6_rst_grant", issue_grant_o, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("t6_rst_valid", exec_valid_o, 0);
        check_eq("t6_rst_cnt", issue_count_o, 0);
        check_eq("t6_rst_idx", exec_idx_o, 0);
        check_eq("t6_rst_op", exec_op_o, 0);
        check_eq("t6_rst_rr", issue_grant_o, 8'b0000_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
